// File: rtl/brightness_filter_pkg.sv
// -----------------------------------------------------------------------------
// brightness_filter_pkg
//   Shared defaults and helpers for the brightness filter.
//   - BITS_DEFAULT    : default pixel / brightness width
//   - MAX_BPM_DEFAULT : BPM value that maps to full-scale brightness
//   - bpm_width()     : width of the BPM_estimate port for a given MAX_BPM
// -----------------------------------------------------------------------------
package brightness_filter_pkg;

  localparam int BITS_DEFAULT    = 8;
  localparam int MAX_BPM_DEFAULT = 200;

  // Enough bits to carry every value 0..max_bpm.
  function automatic int bpm_width(input int max_bpm);
    return $clog2(max_bpm + 1);
  endfunction

endpackage : brightness_filter_pkg

// File: rtl/brightness_filter_bpm_to_brightness.sv
// -----------------------------------------------------------------------------
// bpm_to_brightness
//   Purely combinational map from a heart-rate estimate to a brightness
//   offset: floor(min(bpm, MAX_BPM) * (2^BITS - 1) / MAX_BPM).
//   The divisor is a constant, so the divide reduces to fixed logic.
//
// Ports
//   bpm        in  [bpm_width(MAX_BPM)-1:0]  heart-rate estimate
//   brightness out [BITS-1:0]                mapped brightness offset
// -----------------------------------------------------------------------------
module bpm_to_brightness
  import brightness_filter_pkg::*;
#(
  parameter int BITS    = BITS_DEFAULT,
  parameter int MAX_BPM = MAX_BPM_DEFAULT
) (
  input  logic [bpm_width(MAX_BPM)-1:0] bpm,
  output logic [BITS-1:0]               brightness
);

  localparam int BPM_W  = bpm_width(MAX_BPM);
  // Product of a clamped BPM and a BITS-wide full scale never exceeds this.
  localparam int PROD_W = BPM_W + BITS;

  localparam logic [PROD_W-1:0] FULL_SCALE = PROD_W'((1 << BITS) - 1);
  localparam logic [PROD_W-1:0] DIVISOR    = PROD_W'(MAX_BPM);

  logic [BPM_W-1:0]  bpm_clamped;
  logic [PROD_W-1:0] product;

  always_comb begin
    bpm_clamped = bpm;
    // Anything above MAX_BPM pins at full scale.
    if (bpm > BPM_W'(MAX_BPM)) begin
      bpm_clamped = BPM_W'(MAX_BPM);
    end
    product    = PROD_W'(bpm_clamped) * FULL_SCALE;
    // The quotient is at most 2^BITS - 1, so truncation loses nothing.
    brightness = BITS'(product / DIVISOR);
  end

endmodule : bpm_to_brightness

// File: rtl/brightness_filter.sv
// -----------------------------------------------------------------------------
// brightness_filter
//   Adds a heart-rate-derived brightness offset to a pixel stream through a
//   single output register stage with valid/ready flow control.
//
// Ports
//   clk           in   single clock, all logic on posedge
//   reset         in   synchronous, active-high reset
//   pix_in        in   [BITS-1:0] upstream pixel
//   valid_in      in   pix_in valid
//   output_ready  out  block can accept pix_in this cycle
//   module_ready  in   downstream can accept pix_out this cycle
//   filter_enable in   1 = add brightness, 0 = pass pixel through unchanged
//   BPM_estimate  in   [bpm_width(MAX_BPM)-1:0] heart-rate estimate
//   pix_out       out  [BITS-1:0] processed pixel
//   valid_out     out  pix_out valid
//   brightness    out  [BITS-1:0] registered brightness offset
//
// Configuration
//   BRIGHTNESS_FILTER_SATURATE_EN defined   : pix_in + brightness clips at
//                                             2^BITS - 1.
//   BRIGHTNESS_FILTER_SATURATE_EN undefined : sum wraps modulo 2^BITS.
//
// Handshake: a transfer happens on a posedge where valid and ready are both
// high. Upstream: valid_in/output_ready; downstream: valid_out/module_ready.
// Once valid_out is high, pix_out and valid_out hold until module_ready is
// seen high. output_ready depends combinationally on module_ready so the
// single stage can stream one pixel per clock.
// -----------------------------------------------------------------------------
module brightness_filter
  import brightness_filter_pkg::*;
#(
  parameter int BITS    = BITS_DEFAULT,
  parameter int MAX_BPM = MAX_BPM_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BITS-1:0]               pix_in,
  input  logic                          valid_in,
  output logic                          output_ready,
  input  logic                          module_ready,
  input  logic                          filter_enable,
  input  logic [bpm_width(MAX_BPM)-1:0] BPM_estimate,
  output logic [BITS-1:0]               pix_out,
  output logic                          valid_out,
  output logic [BITS-1:0]               brightness
);

  logic [BITS-1:0] bright_map;

  logic [BITS-1:0] brightness_d, brightness_q;
  logic [BITS-1:0] pix_out_d,    pix_out_q;
  logic            valid_out_d,  valid_out_q;

  logic            accept;
  logic [BITS-1:0] filtered;

  bpm_to_brightness #(
    .BITS    (BITS),
    .MAX_BPM (MAX_BPM)
  ) u_bpm_to_brightness (
    .bpm        (BPM_estimate),
    .brightness (bright_map)
  );

  // Ready when the stage is empty or its content leaves this cycle; never
  // while reset is high so nothing is taken in during reset.
  assign output_ready = ~reset & (module_ready | ~valid_out_q);
  assign accept       = valid_in & output_ready;

`ifdef BRIGHTNESS_FILTER_SATURATE_EN
  logic [BITS:0] sum;

  always_comb begin
    sum      = {1'b0, pix_in} + {1'b0, brightness_q};
    filtered = sum[BITS] ? {BITS{1'b1}} : sum[BITS-1:0];
  end
`else
  always_comb begin
    filtered = pix_in + brightness_q;
  end
`endif

  always_comb begin
    brightness_d = bright_map;
    pix_out_d    = pix_out_q;
    valid_out_d  = valid_out_q;

    if (accept) begin
      // Enable and brightness are both taken from the acceptance cycle.
      pix_out_d   = filter_enable ? filtered : pix_in;
      valid_out_d = 1'b1;
    end else if (module_ready) begin
      valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      brightness_q <= '0;
      pix_out_q    <= '0;
      valid_out_q  <= 1'b0;
    end else begin
      brightness_q <= brightness_d;
      pix_out_q    <= pix_out_d;
      valid_out_q  <= valid_out_d;
    end
  end

  assign pix_out    = pix_out_q;
  assign valid_out  = valid_out_q;
  assign brightness = brightness_q;

endmodule : brightness_filter

// File: tb/tb_brightness_filter.sv
// -----------------------------------------------------------------------------
// tb_brightness_filter
//   Directed, table-driven bench for brightness_filter with default
//   parameters (BITS=8, MAX_BPM=200). Expected values are hand-computed for
//   both the saturating and the wrapping build.
// -----------------------------------------------------------------------------
module tb_brightness_filter;

`ifdef BRIGHTNESS_FILTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pix_in;
  logic       valid_in;
  logic       output_ready;
  logic       module_ready;
  logic       filter_enable;
  logic [7:0] BPM_estimate;
  logic [7:0] pix_out;
  logic       valid_out;
  logic [7:0] brightness;

  always #5 clk = ~clk;

  brightness_filter dut (
    .clk           (clk),
    .reset         (reset),
    .pix_in        (pix_in),
    .valid_in      (valid_in),
    .output_ready  (output_ready),
    .module_ready  (module_ready),
    .filter_enable (filter_enable),
    .BPM_estimate  (BPM_estimate),
    .pix_out       (pix_out),
    .valid_out     (valid_out),
    .brightness    (brightness)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_passed = 0;
  int xfer_cnt = 0;

  // Downstream transfers, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!reset && valid_out && module_ready) xfer_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] bpm;
    logic [7:0] pix;
    logic [7:0] exp_bright;
    logic [7:0] exp_sat;
    logic [7:0] exp_wrap;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] stream_sat  [10] = '{102, 122, 142, 162, 182, 202, 222, 242, 255, 255};
  logic [7:0] stream_wrap [10] = '{102, 122, 142, 162, 182, 202, 222, 242,   6,  26};

  initial begin
    // Transparency, BPM=100 -> brightness 127
    vecs.push_back('{1'b0, 8'd100, 8'd50,  8'd127, 8'd50,  8'd50 });
    vecs.push_back('{1'b0, 8'd100, 8'd100, 8'd127, 8'd100, 8'd100});
    vecs.push_back('{1'b0, 8'd100, 8'd150, 8'd127, 8'd150, 8'd150});
    vecs.push_back('{1'b0, 8'd100, 8'd200, 8'd127, 8'd200, 8'd200});
    vecs.push_back('{1'b0, 8'd100, 8'd255, 8'd127, 8'd255, 8'd255});
    // Addition / saturation, BPM=50 -> 63
    vecs.push_back('{1'b1, 8'd50,  8'd0,   8'd63,  8'd63,  8'd63 });
    vecs.push_back('{1'b1, 8'd50,  8'd50,  8'd63,  8'd113, 8'd113});
    vecs.push_back('{1'b1, 8'd50,  8'd100, 8'd63,  8'd163, 8'd163});
    vecs.push_back('{1'b1, 8'd50,  8'd150, 8'd63,  8'd213, 8'd213});
    vecs.push_back('{1'b1, 8'd50,  8'd192, 8'd63,  8'd255, 8'd255});
    vecs.push_back('{1'b1, 8'd50,  8'd200, 8'd63,  8'd255, 8'd7  });
    // BPM=150 -> 191
    vecs.push_back('{1'b1, 8'd150, 8'd0,   8'd191, 8'd191, 8'd191});
    vecs.push_back('{1'b1, 8'd150, 8'd50,  8'd191, 8'd241, 8'd241});
    vecs.push_back('{1'b1, 8'd150, 8'd64,  8'd191, 8'd255, 8'd255});
    // Enable toggle, BPM=100 -> 127
    vecs.push_back('{1'b1, 8'd100, 8'd50,  8'd127, 8'd177, 8'd177});
    vecs.push_back('{1'b0, 8'd100, 8'd50,  8'd127, 8'd50,  8'd50 });
    vecs.push_back('{1'b1, 8'd100, 8'd50,  8'd127, 8'd177, 8'd177});
    vecs.push_back('{1'b0, 8'd100, 8'd50,  8'd127, 8'd50,  8'd50 });
    // Mapping endpoints: 80 -> 102, 200 -> 255, above MAX_BPM clamps
    vecs.push_back('{1'b1, 8'd80,  8'd0,   8'd102, 8'd102, 8'd102});
    vecs.push_back('{1'b1, 8'd200, 8'd0,   8'd255, 8'd255, 8'd255});
    vecs.push_back('{1'b1, 8'd250, 8'd0,   8'd255, 8'd255, 8'd255});

    // ---- reset state
    reset = 1'b1; valid_in = 1'b0; pix_in = '0; module_ready = 1'b1;
    filter_enable = 1'b0; BPM_estimate = 8'd100;
    tick(); tick();
    check("reset_pix_out",      pix_out,      0);
    check("reset_valid_out",    valid_out,    0);
    check("reset_brightness",   brightness,   0);
    check("reset_output_ready", output_ready, 0);
    reset = 1'b0;
    #1;
    check("post_reset_output_ready", output_ready, 1);

    // ---- table-driven single pixels
    foreach (vecs[i]) begin
      BPM_estimate  = vecs[i].bpm;
      filter_enable = vecs[i].en;
      valid_in      = 1'b0;
      tick();
      check($sformatf("vec%0d_brightness", i), brightness, vecs[i].exp_bright);
      check($sformatf("vec%0d_idle_valid", i), valid_out, 0);
      pix_in   = vecs[i].pix;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      check($sformatf("vec%0d_valid_out", i), valid_out, 1);
      check($sformatf("vec%0d_pix_out", i), pix_out,
            SAT ? vecs[i].exp_sat : vecs[i].exp_wrap);
    end

    // ---- backpressure: pixel 100 + 127 held for 3 stalled cycles
    BPM_estimate = 8'd100; filter_enable = 1'b1;
    tick();
    pix_in = 8'd100; valid_in = 1'b1; module_ready = 1'b0;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d_valid_out", k),    valid_out,    1);
      check($sformatf("bp%0d_pix_out", k),      pix_out,      227);
      check($sformatf("bp%0d_output_ready", k), output_ready, 0);
      tick();
    end
    xfer_cnt     = 0;
    module_ready = 1'b1;
    #1;
    check("bp_release_output_ready", output_ready, 1);
    tick(); tick(); tick();
    check("bp_valid_after_release", valid_out, 0);
    check("bp_transfer_count",      xfer_cnt,  1);

    // ---- streaming, BPM=80 -> 102, one pixel per clock
    BPM_estimate = 8'd80; filter_enable = 1'b1;
    tick();
    xfer_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      pix_in   = 8'(i * 20);
      valid_in = 1'b1;
      #1;
      check($sformatf("stream%0d_output_ready", i), output_ready, 1);
      tick();
      check($sformatf("stream%0d_valid_out", i), valid_out, 1);
      check($sformatf("stream%0d_pix_out", i), pix_out,
            SAT ? stream_sat[i] : stream_wrap[i]);
    end
    valid_in = 1'b0;
    tick();
    check("stream_drained_valid", valid_out, 0);
    check("stream_transfer_count", xfer_cnt, 10);

    // ---- reset mid-stream
    BPM_estimate = 8'd100; filter_enable = 1'b1;
    tick();
    pix_in = 8'd10; valid_in = 1'b1;
    tick();
    check("rst_pre_valid_out", valid_out, 1);
    check("rst_pre_pix_out",   pix_out,   137);
    reset  = 1'b1;
    pix_in = 8'd20;
    tick();
    check("rst_mid_pix_out",      pix_out,      0);
    check("rst_mid_valid_out",    valid_out,    0);
    check("rst_mid_brightness",   brightness,   0);
    check("rst_mid_output_ready", output_ready, 0);
    tick();
    check("rst_hold_valid_out", valid_out, 0);
    reset    = 1'b0;
    valid_in = 1'b0;
    tick();
    check("rst_exit_brightness", brightness, 127);
    check("rst_exit_valid_out",  valid_out,  0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule : tb_brightness_filter
